// File: rtl/score_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// score_pkg: shared types and defaults for the score BCD converter
// Rev 1.0
// ------------------------------------------------------------------
package score_pkg;

  localparam int MAX_SCORE_DEF = 9999;
  localparam int N_DIGITS_DEF  = 4;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SHIFT   = 2'd1,
    S_PUBLISH = 2'd2
  } bcd_state_t;

endpackage : score_pkg
`default_nettype wire

// File: rtl/bcd_digit_adjust.sv
`default_nettype none
// ------------------------------------------------------------------
// bcd_digit_adjust: add-3 correction for one BCD digit before a shift
// Rev 1.0
// ------------------------------------------------------------------
module bcd_digit_adjust
  import score_pkg::*;
(
  input  bcd_digit_t i_digit,
  output bcd_digit_t o_digit
);

  // Digit never exceeds 9 before adjust, so 4-bit arithmetic cannot wrap.
  assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule : bcd_digit_adjust
`default_nettype wire

// File: rtl/score_bcd_converter.sv
`default_nettype none
// ------------------------------------------------------------------
// score_bcd_converter: re-converts the binary score to packed BCD on change
// Rev 1.0
// ------------------------------------------------------------------
module score_bcd_converter
  import score_pkg::*;
#(
  parameter  int MAX_SCORE = MAX_SCORE_DEF,
  parameter  int N_DIGITS  = N_DIGITS_DEF,
  localparam int BIN_W     = $clog2(MAX_SCORE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_W-1:0]      bin_in,
  output logic [4*N_DIGITS-1:0] bcd_out,
  output logic                  bcd_valid,
  output logic                  busy,
  output logic                  saturated
);

  localparam int                 CNT_W   = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam int                 DIG_W   = 4 * N_DIGITS;
  localparam logic [BIN_W-1:0]   C_MAX   = BIN_W'(MAX_SCORE);
  localparam logic [CNT_W-1:0]   C_LAST  = CNT_W'(BIN_W - 1);

  generate
    if (10 ** N_DIGITS <= MAX_SCORE) begin : g_param_check
      $error("N_DIGITS too small to represent MAX_SCORE");
    end
  endgenerate

  bcd_state_t         r_state;
  logic [DIG_W-1:0]   r_bcd;
  logic               r_valid;
  logic               r_busy;
  logic               r_sat;
  logic               r_sat_q;
  logic               r_first_pending;
  logic [BIN_W-1:0]   r_last_conv;
  logic [BIN_W-1:0]   r_shift_bin;
  logic [DIG_W-1:0]   r_digits;
  logic [CNT_W-1:0]   r_bit_cnt;

  logic [DIG_W-1:0]       w_adj;
  logic [DIG_W+BIN_W-1:0] w_cat;
  logic [DIG_W-1:0]       w_next_digits;
  logic [BIN_W-1:0]       w_next_bin;
  logic                   w_start;
  logic                   w_over;
  logic [BIN_W-1:0]       w_clamped;

  generate
    for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
      bcd_digit_adjust u_adj (
        .i_digit (r_digits[4*g +: 4]),
        .o_digit (w_adj[4*g +: 4])
      );
    end
  endgenerate

  always_comb begin
    w_cat         = {w_adj, r_shift_bin};
    w_next_digits = w_cat[DIG_W+BIN_W-2 -: DIG_W];
    w_next_bin    = {w_cat[BIN_W-2:0], 1'b0};
    w_start       = (bin_in != r_last_conv) || r_first_pending;
    w_over        = (bin_in > C_MAX);
    w_clamped     = w_over ? C_MAX : bin_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_bcd           <= '0;
      r_valid         <= 1'b0;
      r_busy          <= 1'b0;
      r_sat           <= 1'b0;
      r_sat_q         <= 1'b0;
      r_first_pending <= 1'b1;
      r_last_conv     <= '0;
      r_shift_bin     <= '0;
      r_digits        <= '0;
      r_bit_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_last_conv     <= bin_in;
            r_first_pending <= 1'b0;
            r_sat_q         <= w_over;
            r_shift_bin     <= w_clamped;
            r_digits        <= '0;
            r_bit_cnt       <= '0;
            r_busy          <= 1'b1;
            r_state         <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_digits    <= w_next_digits;
          r_shift_bin <= w_next_bin;
          if (r_bit_cnt == C_LAST) begin
            r_state <= S_PUBLISH;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        S_PUBLISH: begin
          // Published value only changes here, so the display never sees partial digits.
          r_bcd   <= r_digits;
          r_sat   <= r_sat_q;
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bcd_out   = r_bcd;
  assign bcd_valid = r_valid;
  assign busy      = r_busy;
  assign saturated = r_sat;

endmodule : score_bcd_converter
`default_nettype wire

// File: tb/tb_score_bcd_converter.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_score_bcd_converter: directed and randomized checks against a decimal model
// Rev 1.0
// ------------------------------------------------------------------
module tb_score_bcd_converter;

  localparam int BIN_W = 14;

  logic              clk;
  logic              rst;
  logic [BIN_W-1:0]  bin_in;
  logic [15:0]       bcd_out;
  logic              bcd_valid;
  logic              busy;
  logic              saturated;

  int n_tests;
  int n_fail;

  score_bcd_converter dut (
    .clk       (clk),
    .rst       (rst),
    .bin_in    (bin_in),
    .bcd_out   (bcd_out),
    .bcd_valid (bcd_valid),
    .busy      (busy),
    .saturated (saturated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model_bcd(input int x);
    int v;
    v = (x > 9999) ? 9999 : x;
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic test_reset();
    rst    = 1'b1;
    bin_in = '0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({bcd_out, bcd_valid, busy, saturated} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_state: got bcd=%h valid=%b busy=%b sat=%b, expected all zero",
               bcd_out, bcd_valid, busy, saturated);
    end
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      n_tests++;
      if (i <= 15) begin
        if (busy !== 1'b1 || bcd_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL first_conv_busy[%0d]: got busy=%b valid=%b, expected busy=1 valid=0",
                   i, busy, bcd_valid);
        end
      end else if (bcd_out !== 16'h0000 || bcd_valid !== 1'b1 || busy !== 1'b0 || saturated !== 1'b0) begin
        n_fail++;
        $display("FAIL first_conv_result: got bcd=%h valid=%b busy=%b sat=%b, expected 0000 1 0 0",
                 bcd_out, bcd_valid, busy, saturated);
      end
    end
  endtask

  task automatic test_latency();
    bin_in = 14'd1234;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      n_tests++;
      if (i <= 15) begin
        if (busy !== 1'b1 || bcd_out !== 16'h0000) begin
          n_fail++;
          $display("FAIL latency_hold[%0d]: got busy=%b bcd=%h, expected busy=1 bcd=0000",
                   i, busy, bcd_out);
        end
      end else if (busy !== 1'b0 || bcd_out !== 16'h1234) begin
        n_fail++;
        $display("FAIL latency_result: got busy=%b bcd=%h, expected busy=0 bcd=1234", busy, bcd_out);
      end
    end
  endtask

  task automatic test_saturate();
    int vals [3];
    vals = '{9999, 12000, 42};
    foreach (vals[k]) begin
      bin_in = BIN_W'(vals[k]);
      repeat (17) @(negedge clk);
      n_tests++;
      if (bcd_out !== model_bcd(vals[k]) || saturated !== (vals[k] > 9999)) begin
        n_fail++;
        $display("FAIL saturate_%0d: got bcd=%h sat=%b, expected bcd=%h sat=%b",
                 vals[k], bcd_out, saturated, model_bcd(vals[k]), vals[k] > 9999);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_bcd;
    logic        exp_busy;
    bin_in = 14'd57;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (i <= 15)      begin exp_busy = 1'b1; exp_bcd = 16'h0042; end
      else if (i == 16) begin exp_busy = 1'b0; exp_bcd = 16'h0057; end
      else if (i <= 31) begin exp_busy = 1'b1; exp_bcd = 16'h0057; end
      else              begin exp_busy = 1'b0; exp_bcd = 16'h4321; end
      n_tests++;
      if (busy !== exp_busy || bcd_out !== exp_bcd) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got busy=%b bcd=%h, expected busy=%b bcd=%h",
                 i, busy, bcd_out, exp_busy, exp_bcd);
      end
      if (i == 3) bin_in = 14'd4321;
    end
  endtask

  task automatic test_reset_abort();
    bin_in = 14'd8765;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({bcd_out, bcd_valid, busy, saturated} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_abort: got bcd=%h valid=%b busy=%b sat=%b, expected all zero",
               bcd_out, bcd_valid, busy, saturated);
    end
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 1) begin
        n_tests++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL reset_restart_busy: got %b, expected 1", busy);
        end
      end
    end
    n_tests++;
    if (bcd_out !== 16'h8765 || bcd_valid !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_restart_result: got bcd=%h valid=%b busy=%b, expected 8765 1 0",
               bcd_out, bcd_valid, busy);
    end
  endtask

  task automatic test_random();
    int x;
    for (int n = 0; n < 2000; n++) begin
      // Occasionally repeat the previous value to exercise the no-change path.
      if ($urandom_range(7, 0) != 0) x = int'($urandom_range(16383, 0));
      else                           x = int'(bin_in);
      bin_in = BIN_W'(x);
      repeat (17) @(negedge clk);
      n_tests++;
      if (bcd_out !== model_bcd(x) || saturated !== (x > 9999) || busy !== 1'b0 || bcd_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL random[%0d] x=%0d: got bcd=%h sat=%b busy=%b valid=%b, expected bcd=%h sat=%b busy=0 valid=1",
                 n, x, bcd_out, saturated, busy, bcd_valid, model_bcd(x), x > 9999);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    bin_in  = '0;
    test_reset();
    test_latency();
    test_saturate();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_score_bcd_converter
`default_nettype wire
